// File: rtl/arm_pkg.sv
// Shared definitions for the block-transfer sequencer: state encoding and word size.
package arm_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Request, memory-beat and completion signals of the LDM/STM sequencer.
interface ldm_stm_sequencer_if;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic        up;
  logic        pre;
  logic        load;
  logic        xfer_ready;
  logic        busy;
  logic        xfer_valid;
  logic [3:0]  xfer_reg;
  logic [31:0] xfer_addr;
  logic        xfer_load;
  logic        xfer_last;
  logic        done;
  logic [31:0] wb_addr;
  logic [4:0]  xfer_count;

  modport slave (
    input  start, reg_list, base_addr, up, pre, load, xfer_ready,
    output busy, xfer_valid, xfer_reg, xfer_addr, xfer_load, xfer_last, done, wb_addr, xfer_count
  );

  modport master (
    output start, reg_list, base_addr, up, pre, load, xfer_ready,
    input  busy, xfer_valid, xfer_reg, xfer_addr, xfer_load, xfer_last, done, wb_addr, xfer_count
  );
endinterface

// File: rtl/lowest_bit_encoder16.sv
// Index of the lowest set bit of a 16-bit vector; any_o flags a non-zero input.
module lowest_bit_encoder16 (
  input  logic [15:0] bits_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);
  // Scanning downwards lets the lowest set bit win the last assignment.
  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bits_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |bits_i;
endmodule

// File: rtl/ldm_stm_sequencer.sv
// Walks a 16-bit register list as one memory beat per accepted cycle, lowest register first,
// then pulses done with the base writeback value. Beat fields hold while xfer_ready is low.
module ldm_stm_sequencer
  import arm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  ldm_stm_sequencer_if.slave   bus
);
  seq_state_e  state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wb_q, wb_d;
  logic        load_q, load_d;
  logic [4:0]  count_q, count_d;

  logic [4:0]  pop_n;
  logic [31:0] base_w, span_w, first_addr;
  logic [3:0]  low_idx;
  logic        low_any;
  logic        one_left;

  lowest_bit_encoder16 u_lbe (
    .bits_i (list_q),
    .idx_o  (low_idx),
    .any_o  (low_any)
  );

  always_comb begin
    pop_n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop_n = pop_n + {4'd0, bus.reg_list[i]};
    end
  end

  assign base_w = {bus.base_addr[31:2], 2'b00};
  assign span_w = 32'(pop_n) * WORD_BYTES;

  // Beats always climb in address, so decrement modes start at the bottom of the block.
  always_comb begin
    case ({bus.up, bus.pre})
      2'b11:   first_addr = base_w + WORD_BYTES;
      2'b10:   first_addr = base_w;
      2'b01:   first_addr = base_w - span_w;
      default: first_addr = base_w - span_w + WORD_BYTES;
    endcase
  end

  assign one_left = low_any && ((list_q & (list_q - 16'd1)) == 16'd0);

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    load_d  = load_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          list_d  = bus.reg_list;
          addr_d  = first_addr;
          wb_d    = bus.up ? (base_w + span_w) : (base_w - span_w);
          load_d  = bus.load;
          count_d = pop_n;
          state_d = (pop_n == 5'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (bus.xfer_ready) begin
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + WORD_BYTES;
          if (one_left) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      list_q  <= 16'd0;
      addr_q  <= 32'd0;
      wb_q    <= 32'd0;
      load_q  <= 1'b0;
      count_q <= 5'd0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.xfer_valid = (state_q == XFER);
  assign bus.xfer_reg   = low_idx;
  assign bus.xfer_addr  = addr_q;
  assign bus.xfer_load  = load_q;
  assign bus.xfer_last  = (state_q == XFER) && one_left;
  assign bus.done       = (state_q == DONE);
  assign bus.wb_addr    = wb_q;
  assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench: a transfer-level model predicts every beat and the writeback; literals pin key results.
module tb_ldm_stm_sequencer;
  logic clk;
  logic reset_n;
  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [3:0]  exp_reg[$];
  logic [31:0] exp_addr[$];
  logic [3:0]  obs_reg[$];
  logic [31:0] obs_addr[$];
  logic [31:0] exp_wb;
  logic        exp_load;
  logic [4:0]  exp_count;
  bit          done_expected = 0;
  int          valid_cycles = 0;

  int          start_cyc, done_cyc, lat;
  logic [31:0] done_wb;
  logic [4:0]  done_count;
  logic        done_load;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: n set bits form a contiguous block of words; beat k (k-th set bit) sits at lowest+4k.
  task automatic expect_xfer(input logic [15:0] l, input logic [31:0] b, input logic u, input logic p,
                             input logic ld);
    logic [31:0] bb, n, lo, k;
    bb = b & 32'hFFFF_FFFC;
    n = 0;
    for (int i = 0; i < 16; i++) if (l[i]) n = n + 1;
    if (u) lo = p ? bb + 4 : bb;
    else   lo = p ? bb - 4 * n : bb - 4 * n + 4;
    exp_reg.delete();
    exp_addr.delete();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        exp_reg.push_back(4'(i));
        exp_addr.push_back(lo + 4 * k);
        k = k + 1;
      end
    end
    exp_wb        = u ? bb + 4 * n : bb - 4 * n;
    exp_load      = ld;
    exp_count     = 5'(n);
    done_expected = 1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.xfer_valid) begin
        valid_cycles++;
        check("beat_expected", 32'(exp_reg.size() != 0), 32'd1);
        if (exp_reg.size() != 0) begin
          check("xfer_reg", 32'(bus.xfer_reg), 32'(exp_reg[0]));
          check("xfer_addr", bus.xfer_addr, exp_addr[0]);
          check("xfer_last", 32'(bus.xfer_last), 32'(exp_reg.size() == 1));
          check("xfer_load", 32'(bus.xfer_load), 32'(exp_load));
          check("xfer_count", 32'(bus.xfer_count), 32'(exp_count));
          if (bus.xfer_ready) begin
            obs_reg.push_back(bus.xfer_reg);
            obs_addr.push_back(bus.xfer_addr);
            void'(exp_reg.pop_front());
            void'(exp_addr.pop_front());
          end
        end
      end
      if (bus.done) begin
        check("done_expected", 32'(done_expected), 32'd1);
        if (done_expected) begin
          check("wb_addr", bus.wb_addr, exp_wb);
          check("beats_left_at_done", 32'(exp_reg.size()), 32'd0);
          done_expected = 0;
        end
      end
    end
  end

  task automatic run_xfer(input logic [15:0] l, input logic [31:0] b, input logic u, input logic p,
                          input logic ld, input int stall, input bit poke);
    bit got;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.reg_list   = l;
    bus.base_addr  = b;
    bus.up         = u;
    bus.pre        = p;
    bus.load       = ld;
    bus.xfer_ready = (stall == 0);
    expect_xfer(l, b, u, p, ld);
    obs_reg.delete();
    obs_addr.delete();
    valid_cycles = 0;
    @(posedge clk);
    #1;
    start_cyc     = cyc;
    bus.start     = 1'b0;
    bus.reg_list  = 16'hFFFF;
    bus.base_addr = 32'hDEAD_BEE0;
    bus.up        = ~u;
    bus.pre       = ~p;
    bus.load      = ~ld;
    if (poke) begin
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 bus.xfer_ready = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got        = 1;
        done_cyc   = cyc;
        done_wb    = bus.wb_addr;
        done_count = bus.xfer_count;
        done_load  = bus.xfer_load;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    lat = done_cyc - start_cyc + 2;
  endtask

  task automatic after_done(input logic [31:0] wb);
    @(negedge clk);
    check("wb_hold", bus.wb_addr, wb);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.start      = 1'b0;
    bus.reg_list   = 16'd0;
    bus.base_addr  = 32'd0;
    bus.up         = 1'b0;
    bus.pre        = 1'b0;
    bus.load       = 1'b0;
    bus.xfer_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.xfer_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_addr", bus.xfer_addr, 32'd0);
    check("rst_wb", bus.wb_addr, 32'd0);
    check("rst_count", 32'(bus.xfer_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // STM IA
    run_xfer(16'h8005, 32'h1000, 1'b1, 1'b0, 1'b0, 0, 0);
    check("ia_latency", 32'(lat), 32'd5);
    check("ia_wb", done_wb, 32'h100C);
    check("ia_count", 32'(done_count), 32'd3);
    check("ia_beat2_reg", 32'(obs_reg.size() == 3 ? obs_reg[2] : 4'd0), 32'd15);
    check("ia_beat2_addr", obs_addr.size() == 3 ? obs_addr[2] : 32'd0, 32'h1008);
    after_done(32'h100C);

    // LDM DB
    run_xfer(16'h00F0, 32'h2000, 1'b0, 1'b1, 1'b1, 0, 0);
    check("db_wb", done_wb, 32'h1FF0);
    check("db_load", 32'(done_load), 32'd1);
    check("db_first_addr", obs_addr.size() == 4 ? obs_addr[0] : 32'd0, 32'h1FF0);
    check("db_last_addr", obs_addr.size() == 4 ? obs_addr[3] : 32'd0, 32'h1FFC);
    check("db_latency", 32'(lat), 32'd6);

    // IB with a three-cycle stall on the first beat
    run_xfer(16'h0003, 32'h0100, 1'b1, 1'b1, 1'b0, 3, 0);
    check("stall_valid_cycles", 32'(valid_cycles), 32'd5);
    check("stall_wb", done_wb, 32'h108);
    check("stall_beat1_addr", obs_addr.size() == 2 ? obs_addr[1] : 32'd0, 32'h108);
    check("stall_latency", 32'(lat), 32'd7);

    // Empty list
    run_xfer(16'h0000, 32'h0500, 1'b1, 1'b0, 1'b0, 0, 0);
    check("empty_latency", 32'(lat), 32'd2);
    check("empty_beats", 32'(valid_cycles), 32'd0);
    check("empty_wb", done_wb, 32'h500);
    check("empty_count", 32'(done_count), 32'd0);

    // Full list
    run_xfer(16'hFFFF, 32'h0000, 1'b1, 1'b0, 1'b0, 0, 0);
    check("full_count", 32'(done_count), 32'd16);
    check("full_wb", done_wb, 32'h40);
    check("full_latency", 32'(lat), 32'd18);
    check("full_last_addr", obs_addr.size() == 16 ? obs_addr[15] : 32'd0, 32'h3C);

    // start pulsed mid-transfer; unaligned base bits dropped
    run_xfer(16'h0007, 32'h0000_0042, 1'b1, 1'b1, 1'b0, 0, 1);
    check("poke_wb", done_wb, 32'h4C);
    check("poke_first_addr", obs_addr.size() == 3 ? obs_addr[0] : 32'd0, 32'h44);
    check("poke_latency", 32'(lat), 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_queued_start", 32'(bus.busy), 32'd0);
    end

    // DA wrap below zero
    run_xfer(16'h0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
    check("wrap_wb", done_wb, 32'hFFFF_FFFC);
    check("wrap_addr", obs_addr.size() == 1 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h0);
    after_done(32'hFFFF_FFFC);

    // Reset after three accepted beats
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.reg_list   = 16'h00FF;
    bus.base_addr  = 32'h3000;
    bus.up         = 1'b1;
    bus.pre        = 1'b0;
    bus.load       = 1'b0;
    bus.xfer_ready = 1'b1;
    expect_xfer(16'h00FF, 32'h3000, 1'b1, 1'b0, 1'b0);
    obs_reg.delete();
    obs_addr.delete();
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_beats", 32'(obs_addr.size()), 32'd3);
    reset_n = 1'b0;
    exp_reg.delete();
    exp_addr.delete();
    done_expected = 0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_valid", 32'(bus.xfer_valid), 32'd0);
    check("rst_mid_last", 32'(bus.xfer_last), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_reg", 32'(bus.xfer_reg), 32'd0);
    check("rst_mid_addr", bus.xfer_addr, 32'd0);
    check("rst_mid_wb", bus.wb_addr, 32'd0);
    check("rst_mid_count", 32'(bus.xfer_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    run_xfer(16'h0001, 32'h3000, 1'b1, 1'b0, 1'b1, 0, 0);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_wb", done_wb, 32'h3004);
    check("post_rst_addr", obs_addr.size() == 1 ? obs_addr[0] : 32'd0, 32'h3000);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 The block SHALL have one clock, `clk`, and one reset, `reset_n`, which is asynchronous and active-low.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a block transfer; sampled only in IDLE.
- `reg_list` in 16: register list; bit i set means register Ri is transferred.
- `base_addr` in 32: base register value; bits [1:0] are ignored and treated as 0.
- `up` in 1: U bit; 1 = increment, 0 = decrement.
- `pre` in 1: P bit; 1 = before, 0 = after.
- `load` in 1: L bit; 1 = LDM, 0 = STM; passed through on `xfer_load`.
- `xfer_ready` in 1: memory accepts the current beat.
- `busy` out 1: high in every state except IDLE.
- `xfer_valid` out 1: a beat is presented.
- `xfer_reg` out 4: register number of the current beat.
- `xfer_addr` out 32: word address of the current beat.
- `xfer_load` out 1: latched L bit.
- `xfer_last` out 1: the current beat is the final one.
- `done` out 1: single-cycle completion pulse.
- `wb_addr` out 32: base writeback value; valid while `done` is high.
- `xfer_count` out 5: number of set bits in the latched list (0..16).

Function
REQ-003 The block SHALL implement three states: IDLE, XFER and DONE.
REQ-004 In IDLE, `start`=1 SHALL latch `reg_list`, `base_addr`, `up`, `pre` and `load`, and compute the popcount n into `xfer_count`.
REQ-005 When started with n>0, the block SHALL enter XFER on the next edge; when started with n=0, it SHALL go directly to DONE with no beats.
REQ-006 The first beat address SHALL be:
- base+4 for increment-before;
- base for increment-after;
- base-4n for decrement-before;
- base-4n+4 for decrement-after.
REQ-007 Beats SHALL be issued in ascending register order at ascending addresses (lowest register at the lowest address), regardless of `up`.
REQ-008 In XFER, `xfer_valid` SHALL be 1 and `xfer_reg` SHALL equal the index of the lowest set bit of the remaining list.
REQ-009 `xfer_addr`, `xfer_reg` and `xfer_last` SHALL be held stable while `xfer_ready`=0 (stall of unbounded length).
REQ-010 On a cycle with `xfer_valid` and `xfer_ready` both high, the block SHALL clear that bit in the remaining list and add 4 to the current address (mod 2^32).
REQ-011 `xfer_last` SHALL be 1 exactly when the remaining list has one bit set; its acceptance SHALL move the state to DONE.
REQ-012 In DONE, `done` SHALL be 1 for exactly one cycle, and `wb_addr` SHALL equal base+4n if up=1, else base-4n; the state SHALL then return to IDLE.
REQ-013 `wb_addr` SHALL hold its value after DONE until the next start.
REQ-014 `start` outside IDLE SHALL be ignored, and no queued request SHALL result.
REQ-015 Address arithmetic SHALL be 32-bit modulo, with silent wrap-around (e.g. base 0x0000_0000, DB, n=1 gives 0xFFFF_FFFC).
REQ-016 Throughput SHALL be one beat per cycle when `xfer_ready` is held high; a transfer with n beats SHALL take n+2 cycles from the `start` edge to the `done` cycle inclusive.
REQ-017 Inputs other than `xfer_ready` SHALL be ignored outside IDLE (the latched copies are used).

Reset
REQ-018 Asserting `reset_n` low SHALL immediately force IDLE, with `busy`, `xfer_valid`, `xfer_last` and `done` at 0 and `xfer_reg`, `xfer_addr`, `wb_addr` and `xfer_count` at 0.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no `done` pulse; after release, the first `start` SHALL begin a fresh transfer.
REQ-020 No output SHALL depend combinationally on `reset_n` other than through the registered state.

Structure
REQ-021 The state encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2) and the constant WORD_BYTES=4 SHALL reside in the shared package arm_pkg.
REQ-022 Lowest-set-bit selection SHALL be a sub-module, lowest_bit_encoder16 (16-bit input, 4-bit index plus 1-bit any output), instantiated once on the remaining list.
REQ-023 The popcount SHALL be computed combinationally in this block and registered at start.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- STM IA: list 0x8005, base 0x1000, up=1, pre=0, ready high -> beats (R0,0x1000), (R2,0x1004), (R15,0x1008, last); done at cycle 5; wb_addr 0x100C.
- LDM DB: list 0x00F0, base 0x2000, up=0, pre=1 -> R4..R7 at 0x1FF0..0x1FFC; wb_addr 0x1FF0; xfer_load=1.
- Stall: IB, list 0x0003, base 0x100, ready low for 3 cycles on beat 1 -> (R0,0x104) held stable 4 cycles, then (R1,0x108); wb_addr 0x108.
- Empty and full lists: list 0x0000 -> no xfer_valid, done on the next cycle, wb_addr = base; list 0xFFFF IA from base 0 -> 16 beats 0x0..0x3C, xfer_count 16, wb_addr 0x40.
- Reset mid-op: list 0x00FF, reset_n low after 3 beats -> all outputs 0, no done; a new start with list 0x0001 completes normally.
- Ignored start and wrap: start pulsed during XFER -> no extra transfer; DA, base 0x0, list 0x0001 -> beat at 0x0, wb_addr 0xFFFF_FFFC.
